// File: rtl/color_centroid_tracker.sv
// Per-frame weighted centroid of one colour channel, divided serially at each frame boundary.
// Define COM_BBOX_EN to add bounding-box outputs over the weighted pixels.
module color_centroid_tracker #(
    parameter int CH_W     = 6,
    parameter int WEIGHT_W = 5,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int ACC_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3*CH_W-1:0]   pixel,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic                pixel_valid,
    input  logic                frame_start,
    input  logic [1:0]          color_select,
    input  logic [WEIGHT_W-1:0] threshold,
    output logic [X_W-1:0]      x_center,
    output logic [Y_W-1:0]      y_center,
    output logic [ACC_W-1:0]    mass,
    output logic                found,
    output logic                center_valid,
    output logic                busy,
    output logic                overrun
`ifdef COM_BBOX_EN
    ,
    output logic [X_W-1:0]      bbox_x_min,
    output logic [X_W-1:0]      bbox_x_max,
    output logic [Y_W-1:0]      bbox_y_min,
    output logic [Y_W-1:0]      bbox_y_max
`endif
);
    localparam int CNT_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ACC_W - 1);

    typedef enum logic {ACCUM, DIVIDE} state_t;
    state_t state, nextState;

    logic [CH_W-1:0]         selCh;
    logic [WEIGHT_W-1:0]     weight, wEff;
    logic [WEIGHT_W+X_W-1:0] prodX;
    logic [WEIGHT_W+Y_W-1:0] prodY;
    logic [ACC_W-1:0]        termX, termY, termW;
    logic [ACC_W-1:0]        sumX, sumY, sumW, nextSumX, nextSumY, nextSumW;
    logic [ACC_W-1:0]        remX, quoX, remY, quoY, divisor;
    logic [2*ACC_W-1:0]      stepX, stepY;
    logic [CNT_W-1:0]        stepCnt;
    logic                    primed, snapTake, lastStep, hit;

    function automatic logic [ACC_W-1:0] satAdd(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // One restoring-division step on {remainder, dividend-shifting-into-quotient}.
    function automatic logic [2*ACC_W-1:0] divStep(input logic [ACC_W-1:0] rem, input logic [ACC_W-1:0] quo,
                                                   input logic [ACC_W-1:0] div);
        logic [ACC_W:0] trial, diff;
        trial = {rem, quo[ACC_W-1]};
        diff  = trial - {1'b0, div};
        if (trial >= {1'b0, div})
            return {diff[ACC_W-1:0], quo[ACC_W-2:0], 1'b1};
        return {trial[ACC_W-1:0], quo[ACC_W-2:0], 1'b0};
    endfunction

    always_comb begin
        case (color_select)
            2'd0:    selCh = pixel[3*CH_W-1 -: CH_W];
            2'd1:    selCh = pixel[2*CH_W-1 -: CH_W];
            default: selCh = pixel[CH_W-1:0];
        endcase
        weight   = WEIGHT_W'(selCh >> (CH_W - WEIGHT_W));
        wEff     = (weight > threshold) ? weight : '0;
        hit      = pixel_valid && (wEff != '0);
        prodX    = {{X_W{1'b0}}, wEff} * {{WEIGHT_W{1'b0}}, x};
        prodY    = {{Y_W{1'b0}}, wEff} * {{WEIGHT_W{1'b0}}, y};
        termX    = pixel_valid ? ACC_W'(prodX) : '0;
        termY    = pixel_valid ? ACC_W'(prodY) : '0;
        termW    = pixel_valid ? ACC_W'(wEff)  : '0;
        nextSumX = frame_start ? termX : satAdd(sumX, termX);
        nextSumY = frame_start ? termY : satAdd(sumY, termY);
        nextSumW = frame_start ? termW : satAdd(sumW, termW);
        stepX    = divStep(remX, quoX, divisor);
        stepY    = divStep(remY, quoY, divisor);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ACCUM;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ACCUM:  if (frame_start && primed && sumW != '0) nextState = DIVIDE;
            DIVIDE: if (stepCnt == LAST_STEP) nextState = ACCUM;
            default: nextState = ACCUM;
        endcase
    end

    always_comb begin
        busy     = (state == DIVIDE);
        snapTake = frame_start && primed && (state == ACCUM);
        lastStep = (state == DIVIDE) && (stepCnt == LAST_STEP);
    end

    // The first frame_start after reset only opens a frame: the partial frame before it is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {sumX, sumY, sumW}                 <= '0;
            {remX, quoX, remY, quoY, divisor}  <= '0;
            stepCnt      <= '0;
            primed       <= 1'b0;
            x_center     <= '0;
            y_center     <= '0;
            mass         <= '0;
            found        <= 1'b0;
            center_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sumX         <= nextSumX;
            sumY         <= nextSumY;
            sumW         <= nextSumW;
            center_valid <= 1'b0;
            if (frame_start) primed <= 1'b1;
            if (frame_start && state == DIVIDE) overrun <= 1'b1;
            if (snapTake) begin
                if (sumW == '0) begin
                    found        <= 1'b0;
                    mass         <= '0;
                    center_valid <= 1'b1;
                end else begin
                    remX    <= '0;
                    quoX    <= sumX;
                    remY    <= '0;
                    quoY    <= sumY;
                    divisor <= sumW;
                    stepCnt <= '0;
                end
            end
            if (state == DIVIDE) begin
                {remX, quoX} <= stepX;
                {remY, quoY} <= stepY;
                stepCnt      <= stepCnt + 1'b1;
                if (lastStep) begin
                    x_center     <= (|stepX[ACC_W-1:X_W]) ? '1 : stepX[X_W-1:0];
                    y_center     <= (|stepY[ACC_W-1:Y_W]) ? '1 : stepY[Y_W-1:0];
                    mass         <= divisor;
                    found        <= 1'b1;
                    center_valid <= 1'b1;
                end
            end
        end
    end

`ifdef COM_BBOX_EN
    logic [X_W-1:0] bxMin, bxMax, sxMin, sxMax;
    logic [Y_W-1:0] byMin, byMax, syMin, syMax;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {bxMin, bxMax, byMin, byMax} <= '0;
            {sxMin, sxMax, syMin, syMax} <= '0;
            {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} <= '0;
        end else begin
            if (frame_start) begin
                bxMin <= hit ? x : '1;
                bxMax <= hit ? x : '0;
                byMin <= hit ? y : '1;
                byMax <= hit ? y : '0;
            end else if (hit) begin
                if (x < bxMin) bxMin <= x;
                if (x > bxMax) bxMax <= x;
                if (y < byMin) byMin <= y;
                if (y > byMax) byMax <= y;
            end
            if (snapTake) begin
                if (sumW == '0) begin
                    {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} <= '0;
                end else begin
                    sxMin <= bxMin;
                    sxMax <= bxMax;
                    syMin <= byMin;
                    syMax <= byMax;
                end
            end
            if (lastStep) begin
                bbox_x_min <= sxMin;
                bbox_x_max <= sxMax;
                bbox_y_min <= syMin;
                bbox_y_max <= syMax;
            end
        end
    end
`endif
endmodule
